// File: rtl/voice_mix_pkg.sv
// voice_mix_pkg: shared FSM encoding, product width and the 8-bit saturate/offset-binary helper.
package voice_mix_pkg;
  typedef enum logic [1:0] {IDLE, READ, FINISH} state_t;
  localparam int PROD_W = 13;
  function automatic logic [7:0] sat_ob(input logic signed [31:0] v);
    logic signed [31:0] c;
    c = v > 32'sd127 ? 32'sd127 : v < -32'sd128 ? -32'sd128 : v;
    return {~c[7], c[6:0]};
  endfunction
endpackage

// File: rtl/voice_mac.sv
// voice_mac: registered signed sample x unsigned volume multiply-accumulate with clear and enable.
module voice_mac import voice_mix_pkg::*; #(
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [7:0]       a,
  input  logic [3:0]              b,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [PROD_W-1:0] prod;
  assign prod = a * $signed({1'b0, b});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + ACC_W'(prod);
endmodule

// File: rtl/voice_mixer8.sv
// voice_mixer8: sequences voice reads through one shared MAC and emits a saturated offset-binary mix per tick.
module voice_mixer8 import voice_mix_pkg::*; #(
  parameter int VOICES = 8,
  parameter int SHIFT  = 6,
  parameter int SEL_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_tick,
  output logic [SEL_W-1:0] voice_sel,
  input  logic [7:0]       voice_data,
  input  logic [3:0]       voice_vol,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);
  localparam int ACC_W = PROD_W + SEL_W;
  state_t state, state_n;
  logic rd_v, start, last, done;
  logic signed [ACC_W-1:0] acc;
  voice_mac #(.ACC_W(ACC_W)) u_mac (
    .clk(clk), .rst_n(rst_n), .clr(start), .en(rd_v),
    .a($signed(voice_data)), .b(voice_vol), .acc(acc)
  );
  // rd_v marks cycles where voice_data belongs to an index issued during READ
  always_comb begin
    start   = state == IDLE && sample_tick;
    last    = voice_sel == SEL_W'(VOICES - 1);
    done    = state == FINISH && !rd_v;
    state_n = start ? READ : state == READ && last ? FINISH : done ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      rd_v      <= 1'b0;
      voice_sel <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      out_data  <= 8'h80;
    end else begin
      state     <= state_n;
      rd_v      <= state == READ;
      voice_sel <= state == READ && !last ? voice_sel + 1'b1 : start || done ? '0 : voice_sel;
      busy      <= start ? 1'b1 : done ? 1'b0 : busy;
      out_valid <= done;
      overrun   <= sample_tick && state != IDLE;
      if (done) out_data <= sat_ob(32'(acc >>> SHIFT));
    end
endmodule

// File: tb/tb_voice_mixer8.sv
// tb_voice_mixer8: randomized and directed mixes checked against an arithmetic reference of the mix rules.
module tb_voice_mixer8;
  localparam int V = 8;
  logic clk = 0, rst_n = 0, sample_tick = 0;
  logic [2:0] voice_sel;
  logic [7:0] voice_data = 0, out_data;
  logic [3:0] voice_vol = 0;
  logic out_valid, busy, overrun;
  int vd[V], vv[V];
  int n_cmp = 0, n_bad = 0;

  voice_mixer8 #(.VOICES(V), .SHIFT(6), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .voice_sel(voice_sel),
    .voice_data(voice_data), .voice_vol(voice_vol), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // voice memory with one-cycle read latency
  always @(posedge clk) begin
    voice_data <= 8'(vd[voice_sel]);
    voice_vol  <= 4'(vv[voice_sel]);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_out();
    int s = 0, q;
    for (int i = 0; i < V; i++) s += vd[i] * vv[i];
    q = s / 64;
    if (s < 0 && s % 64 != 0) q--;
    q = q > 127 ? 127 : q < -128 ? -128 : q;
    return q + 128;
  endfunction

  task automatic set_all(input int d, input int v);
    for (int i = 0; i < V; i++) begin vd[i] = d; vv[i] = v; end
  endtask

  task automatic randomize_voices();
    for (int i = 0; i < V; i++) begin
      vd[i] = int'($urandom_range(0, 255)) - 128;
      vv[i] = int'($urandom_range(0, 15));
    end
  endtask

  // k indexes the falling edge after rising edge T+k; extra>0 raises a tick sampled at T+extra
  task automatic mix(input string tag, input int extra, input bit pre);
    int exp_out;
    exp_out = ref_out();
    if (!pre) begin
      @(negedge clk);
      sample_tick = 1;
    end
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk({tag, ".busy"}, int'(busy), int'(k < 10));
      chk({tag, ".valid"}, int'(out_valid), int'(k == 10));
      chk({tag, ".overrun"}, int'(overrun), int'(extra > 0 && k == extra));
      chk({tag, ".sel"}, int'(voice_sel), k < 8 ? k : k < 10 ? 7 : 0);
      sample_tick = (k + 1 == extra);
    end
    chk({tag, ".data"}, int'(out_data), exp_out);
  endtask

  initial begin
    set_all(0, 0);
    repeat (3) @(negedge clk);
    chk("rst.data", int'(out_data), 128);
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.sel", int'(voice_sel), 0);
    chk("rst.overrun", int'(overrun), 0);
    rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle.sel", int'(voice_sel), 0);
      chk("idle.valid", int'(out_valid), 0);
      chk("idle.data", int'(out_data), 128);
    end

    set_all(0, 0); vd[0] = 64; vv[0] = 15;
    mix("v0", 0, 0);
    chk("v0.const", int'(out_data), 8'h8F);
    set_all(127, 15);
    mix("satp", 0, 0);
    chk("satp.const", int'(out_data), 8'hFF);
    set_all(-128, 15);
    mix("satn", 0, 0);
    chk("satn.const", int'(out_data), 8'h00);
    set_all(0, 0); vd[0] = -1; vv[0] = 1;
    mix("floor", 0, 0);
    chk("floor.const", int'(out_data), 8'h7F);

    randomize_voices();
    mix("ovr", 4, 0);
    randomize_voices();
    mix("fin", 10, 0);
    @(negedge clk);
    chk("fin.ignored", int'(busy), 0);
    randomize_voices();
    mix("gap", 11, 0);
    randomize_voices();
    mix("back", 0, 1);

    set_all(0, 0); vd[0] = 64; vv[0] = 15;
    mix("pre", 0, 0);
    randomize_voices();
    @(negedge clk);
    sample_tick = 1;
    @(negedge clk);
    sample_tick = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    chk("arst.data", int'(out_data), 128);
    chk("arst.busy", int'(busy), 0);
    chk("arst.sel", int'(voice_sel), 0);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("arst.novalid", int'(out_valid), 0);
      chk("arst.idle", int'(busy), 0);
    end
    mix("post", 0, 0);

    for (int n = 0; n < 20; n++) begin
      randomize_voices();
      if (n % 4 == 0) for (int i = 0; i < V; i++) vv[i] = 15;
      mix("rand", 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
